// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and the counter-width helper.
package muldiv_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT  = 2'b00;
  localparam op_t OP_MULTU = 2'b01;
  localparam op_t OP_DIV   = 2'b10;
  localparam op_t OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] FINAL = 2'b10;

  // Smallest r such that 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage control and muldiv_unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_write, lo_write, wd,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_write, lo_write, wd,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring
// trial-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    partial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = {1'b0, partial} - {2'b00, opnd};
    if (is_div) begin
      // Remainder stays below the divisor, so a non-negative trial fits WIDTH bits.
      if (trial[WIDTH+1:WIDTH] == 2'b00) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO registers and mthi/mtlo
// writes; one result bit per cycle, WIDTH+1 edges from accept to result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_t                op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               in_signed;
  logic               in_div;
  logic               in_b_zero;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               div_zero;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc)
  );

  // Operand conditioning for the accepting edge.
  always_comb begin
    in_signed = op_is_signed(bus.op);
    in_div    = op_is_div(bus.op);
    in_b_zero = (bus.b == '0);
    abs_a     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Sign fix-up of the finished magnitudes; unsigned ops latched clear signs.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero = op_is_div(op_q) && (opnd_q == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A simultaneous mthi/mtlo is dropped in favour of the new operation.
          op_d    = bus.op;
          neg_a_d = in_signed & bus.a[WIDTH-1];
          neg_b_d = in_signed & bus.b[WIDTH-1];
          cnt_d   = '0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          if (in_div) begin
            opnd_d  = abs_b;
            // Divide by zero keeps the raw dividend so FINAL can return it in HI.
            acc_d   = {{WIDTH{1'b0}}, in_b_zero ? bus.a : abs_a};
            state_d = in_b_zero ? FINAL : RUN;
          end else begin
            opnd_d  = abs_a;
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            state_d = RUN;
          end
        end else begin
          if (bus.hi_write) hi_d = bus.wd;
          if (bus.lo_write) lo_d = bus.wd;
        end
      end

      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FINAL;
      end

      FINAL: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div_zero) begin
          hi_d  = acc_q[WIDTH-1:0];
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  // The datapath registers are reset too, so an aborted operation leaves
  // nothing behind and HI/LO read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: a 32-bit and an 8-bit
// instance driven on negedges and sampled on negedges.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  int total = 0;
  int bad   = 0;

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus32.start = 1'b0; bus32.op = OP_MULT; bus32.a = '0; bus32.b = '0;
    bus32.hi_write = 1'b0; bus32.lo_write = 1'b0; bus32.wd = '0;
    bus8.start = 1'b0; bus8.op = OP_MULT; bus8.a = '0; bus8.b = '0;
    bus8.hi_write = 1'b0; bus8.lo_write = 1'b0; bus8.wd = '0;
  endtask

  // Drive start now (caller is at a negedge); returns at the negedge after the accept edge.
  task automatic launch32(input op_t op, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    @(negedge clk);
    bus32.start = 1'b0;
  endtask

  task automatic issue32(input op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch32(op, a, b);
  endtask

  task automatic wait_done32(output int lat);
    lat = 0;
    while (bus32.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic issue8(input op_t op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (bus8.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if ({bus32.busy, bus32.done, bus32.div_by_zero} !== 3'b000) begin
      $display("FAIL reset_flags32: got %b want 000", {bus32.busy, bus32.done, bus32.div_by_zero});
      bad++;
    end
    total++;
    if ({bus32.hi, bus32.lo} !== 64'h0) begin
      $display("FAIL reset_hilo32: got %h want 0", {bus32.hi, bus32.lo});
      bad++;
    end
    total++;
    if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.hi, bus8.lo} !== 19'h0) begin
      $display("FAIL reset_all8: got %h want 0", {bus8.busy, bus8.done, bus8.div_by_zero, bus8.hi, bus8.lo});
      bad++;
    end
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat;
    issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++;
    if (bus32.busy !== 1'b1) begin
      $display("FAIL multu_busy_after_accept: got %b want 1", bus32.busy); bad++;
    end
    wait_done32(lat);
    total++;
    if (lat !== 33) begin
      $display("FAIL multu_latency: got %0d want 33", lat); bad++;
    end
    total++;
    if (bus32.busy !== 1'b0) begin
      $display("FAIL multu_busy_in_done: got %b want 0", bus32.busy); bad++;
    end
    total++;
    if ({bus32.hi, bus32.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      $display("FAIL multu_max_result: got %h want fffffffe00000001", {bus32.hi, bus32.lo}); bad++;
    end
    @(negedge clk);
    total++;
    if (bus32.done !== 1'b0) begin
      $display("FAIL done_single_pulse: got %b want 0", bus32.done); bad++;
    end
  endtask

  task automatic test_signed();
    int lat;
    issue32(OP_MULT, 32'hFFFF_FFF9, 32'd3);
    wait_done32(lat);
    total++;
    if ({bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      $display("FAIL mult_neg7x3: got %h want ffffffffffffffeb", {bus32.hi, bus32.lo}); bad++;
    end
    issue32(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done32(lat);
    total++;
    if (lat !== 33 || bus32.lo !== 32'hFFFF_FFFD || bus32.hi !== 32'hFFFF_FFFF) begin
      $display("FAIL div_neg7by2: got lat=%0d hi=%h lo=%h want lat=33 hi=ffffffff lo=fffffffd",
               lat, bus32.hi, bus32.lo); bad++;
    end
    issue32(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_done32(lat);
    total++;
    if (bus32.lo !== 32'h7FFF_FFFC || bus32.hi !== 32'd1) begin
      $display("FAIL divu_big_by2: got hi=%h lo=%h want hi=00000001 lo=7ffffffc", bus32.hi, bus32.lo); bad++;
    end
    issue32(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done32(lat);
    total++;
    if (bus32.lo !== 32'hFFFF_FFFD || bus32.hi !== 32'd1) begin
      $display("FAIL div_7by_neg2: got hi=%h lo=%h want hi=00000001 lo=fffffffd", bus32.hi, bus32.lo); bad++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue32(OP_DIVU, 32'd100, 32'd0);
    wait_done32(lat);
    total++;
    if (lat !== 1) begin
      $display("FAIL dbz_latency: got %0d want 1", lat); bad++;
    end
    total++;
    if (bus32.hi !== 32'd100 || bus32.lo !== 32'hFFFF_FFFF || bus32.div_by_zero !== 1'b1) begin
      $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b want hi=00000064 lo=ffffffff dbz=1",
               bus32.hi, bus32.lo, bus32.div_by_zero); bad++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus32.div_by_zero !== 1'b1) begin
      $display("FAIL dbz_sticky: got %b want 1", bus32.div_by_zero); bad++;
    end
    issue32(OP_MULTU, 32'd2, 32'd3);
    total++;
    if (bus32.div_by_zero !== 1'b0) begin
      $display("FAIL dbz_clear_on_accept: got %b want 0", bus32.div_by_zero); bad++;
    end
    wait_done32(lat);
    total++;
    if (bus32.lo !== 32'd6 || bus32.hi !== 32'd0) begin
      $display("FAIL multu_2x3: got hi=%h lo=%h want hi=00000000 lo=00000006", bus32.hi, bus32.lo); bad++;
    end
  endtask

  task automatic test_overflow();
    int lat;
    issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(lat);
    total++;
    if (bus32.lo !== 32'h8000_0000 || bus32.hi !== 32'd0 || bus32.div_by_zero !== 1'b0) begin
      $display("FAIL div_minint_by_neg1: got hi=%h lo=%h dbz=%b want hi=00000000 lo=80000000 dbz=0",
               bus32.hi, bus32.lo, bus32.div_by_zero); bad++;
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus32.hi_write = 1'b1; bus32.wd = 32'hCAFE_0001;
    @(negedge clk);
    bus32.hi_write = 1'b0;
    total++;
    if (bus32.hi !== 32'hCAFE_0001) begin
      $display("FAIL mthi_setup: got %h want cafe0001", bus32.hi); bad++;
    end
    launch32(OP_MULT, 32'd9, 32'hFFFF_FFFB);
    repeat (5) @(negedge clk);
    bus32.start = 1'b1; bus32.op = OP_MULTU; bus32.a = 32'd1; bus32.b = 32'd1;
    bus32.hi_write = 1'b1; bus32.wd = 32'h1234;
    @(negedge clk);
    bus32.start = 1'b0; bus32.hi_write = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus32.hi !== 32'hCAFE_0001 || bus32.busy !== 1'b1) begin
      $display("FAIL hi_hold_while_busy: got hi=%h busy=%b want hi=cafe0001 busy=1", bus32.hi, bus32.busy); bad++;
    end
    lat = 0;
    while (bus32.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 23 || {bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFD3) begin
      $display("FAIL mult_with_ignored_inputs: got lat=%0d res=%h want lat=23 res=ffffffffffffffd3",
               lat, {bus32.hi, bus32.lo}); bad++;
    end
    @(negedge clk);
    total++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
      $display("FAIL start_not_queued: got busy=%b done=%b want 0 0", bus32.busy, bus32.done); bad++;
    end
    bus32.hi_write = 1'b1; bus32.wd = 32'h1234;
    @(negedge clk);
    bus32.hi_write = 1'b0;
    total++;
    if (bus32.hi !== 32'h1234 || bus32.lo !== 32'hFFFF_FFD3) begin
      $display("FAIL mthi_idle: got hi=%h lo=%h want hi=00001234 lo=ffffffd3", bus32.hi, bus32.lo); bad++;
    end
    bus32.hi_write = 1'b1; bus32.lo_write = 1'b1; bus32.wd = 32'hABCD;
    @(negedge clk);
    bus32.hi_write = 1'b0; bus32.lo_write = 1'b0;
    total++;
    if (bus32.hi !== 32'hABCD || bus32.lo !== 32'hABCD) begin
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want 0000abcd 0000abcd", bus32.hi, bus32.lo); bad++;
    end
    bus32.hi_write = 1'b1; bus32.wd = 32'h5555;
    launch32(OP_MULTU, 32'd2, 32'd3);
    bus32.hi_write = 1'b0;
    total++;
    if (bus32.hi !== 32'hABCD || bus32.busy !== 1'b1) begin
      $display("FAIL start_beats_write: got hi=%h busy=%b want hi=0000abcd busy=1", bus32.hi, bus32.busy); bad++;
    end
    wait_done32(lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    issue32(OP_MULTU, 32'd3, 32'd4);
    wait_done32(lat);
    total++;
    if (bus32.lo !== 32'd12) begin
      $display("FAIL b2b_first: got lo=%h want 0000000c", bus32.lo); bad++;
    end
    launch32(OP_DIVU, 32'd13, 32'd4);
    total++;
    if (bus32.busy !== 1'b1) begin
      $display("FAIL b2b_accept: got busy=%b want 1", bus32.busy); bad++;
    end
    wait_done32(lat);
    total++;
    if (lat !== 33 || bus32.lo !== 32'd3 || bus32.hi !== 32'd1) begin
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want lat=33 hi=00000001 lo=00000003",
               lat, bus32.hi, bus32.lo); bad++;
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    issue32(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus32.busy !== 1'b0 || bus32.hi !== 32'd0 || bus32.lo !== 32'd0) begin
      $display("FAIL reset_abort: got busy=%b hi=%h lo=%h want 0 0 0", bus32.busy, bus32.hi, bus32.lo); bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0 || bus32.busy !== 1'b0) begin
      $display("FAIL reset_no_done: got dones=%0d busy=%b want 0 0", dones, bus32.busy); bad++;
    end
  endtask

  task automatic test_width8();
    int lat;
    issue8(OP_MULTU, 8'hFF, 8'hFF);
    wait_done8(lat);
    total++;
    if (lat !== 9 || bus8.hi !== 8'hFE || bus8.lo !== 8'h01) begin
      $display("FAIL w8_multu_ff: got lat=%0d hi=%h lo=%h want lat=9 hi=fe lo=01", lat, bus8.hi, bus8.lo); bad++;
    end
    issue8(OP_MULT, 8'h80, 8'hFF);
    wait_done8(lat);
    total++;
    if (bus8.hi !== 8'h00 || bus8.lo !== 8'h80) begin
      $display("FAIL w8_mult_min_neg1: got hi=%h lo=%h want hi=00 lo=80", bus8.hi, bus8.lo); bad++;
    end
    issue8(OP_DIV, 8'h80, 8'hFF);
    wait_done8(lat);
    total++;
    if (bus8.hi !== 8'h00 || bus8.lo !== 8'h80 || bus8.div_by_zero !== 1'b0) begin
      $display("FAIL w8_div_min_neg1: got hi=%h lo=%h dbz=%b want 00 80 0", bus8.hi, bus8.lo, bus8.div_by_zero); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
